mdu_hilo: RTL and testbench

- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands (rs, rt) and implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Also supports MTHI/MTLO writes and continuously drives HI/LO for MFHI/MFLO.
- Asserts busy so the pipeline control stalls dependent HI/LO accesses.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mdu_hilo_if.sv | 28 ++
 rtl/mdu_datapath.sv | 78 +++++++
 rtl/mdu_hilo.sv | 159 +++++++++++++++
 tb/tb_mdu_hilo.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: multiply/divide op codes, MDU state
// encoding and default datapath width.
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Pipeline <-> multiply/divide unit connection: launch controls, register-file
// operands, HI/LO move-to writes, and the status/HI/LO read-back.
interface mdu_hilo_if #(
  parameter int WIDTH = mips_pkg::WIDTH_DEF
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_in;
  logic [WIDTH-1:0] rt_in;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_in, rt_in, mthi, mtlo,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_in, rt_in, mthi, mtlo,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_datapath.sv
// Iteration registers for the MDU: unsigned shift-add multiply and restoring
// divide, one bit per step, on operand magnitudes. Sign handling is done by
// the controller after the last step.
module mdu_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  // hi: product upper half / partial remainder
  // lo: multiplier shifting out, product lower half shifting in / dividend -> quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q,  b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  // Remainder after a successful subtract is below the divisor, so it fits WIDTH bits.
  assign div_sub   = div_shift[WIDTH-1:0] - b_q;

  // Next-state: load magnitudes at launch, otherwise advance one bit per step.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = opa_i;
      b_d  = opb_i;
    end else if (step_i) begin
      if (is_div_i) begin
        if (div_ge) begin
          hi_d = div_sub;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Iteration registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign acc_hi_o = hi_q;
  assign acc_lo_o = lo_q;

endmodule

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Sequencer for the iterative datapath, sign fix-up, divide-by-zero override
// and MTHI/MTLO writes.
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  mdu_hilo_if.slave  bus
);

  localparam int CW = $clog2(ITER + 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dzero_q;
  logic [WIDTH-1:0] rs_raw_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_e              op_in;
  logic             busy;
  logic             launch;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] opa_mag, opb_mag;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_in   = op_e'(bus.op);
  assign busy    = (state_q == CALC) || (state_q == FIX);
  assign launch  = bus.start && !busy;
  assign a_neg   = op_is_signed(op_in) && bus.rs_in[WIDTH-1];
  assign b_neg   = op_is_signed(op_in) && bus.rt_in[WIDTH-1];
  assign opa_mag = cond_neg(a_neg, bus.rs_in);
  assign opb_mag = cond_neg(b_neg, bus.rt_in);
  assign prod_fix = cond_neg2(qneg_q, {acc_hi, acc_lo});

  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load_i   (launch),
    .step_i   (state_q == CALC),
    .is_div_i (op_is_div(op_q)),
    .opa_i    (opa_mag),
    .opb_i    (opb_mag),
    .acc_hi_o (acc_hi),
    .acc_lo_o (acc_lo)
  );

  // State register and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: IDLE -> CALC (ITER steps) -> FIX -> DONE -> IDLE, or DONE -> CALC on start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = CALC;
          cnt_d   = CW'(ITER - 1);
        end
      end
      CALC: begin
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX:  state_d = DONE;
      DONE: begin
        if (launch) begin
          state_d = CALC;
          cnt_d   = CW'(ITER - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operation context captured at launch so upstream operands may change afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MULT;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      rs_raw_q <= '0;
    end else if (launch) begin
      op_q     <= op_in;
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      dzero_q  <= (bus.rt_in == '0);
      rs_raw_q <= bus.rs_in;
    end
  end

  // HI/LO next value: sign fix-up result in FIX, else MTHI/MTLO when idle and not launching.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FIX) begin
      if (op_is_div(op_q)) begin
        if (dzero_q) begin
          lo_d = '1;
          hi_d = rs_raw_q;
        end else begin
          lo_d = cond_neg(qneg_q, acc_lo);
          hi_d = cond_neg(rneg_q, acc_hi);
        end
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end else if (!busy && !bus.start) begin
      if (bus.mthi) hi_d = bus.rs_in;
      if (bus.mtlo) lo_d = bus.rs_in;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = (state_q == DONE);
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: multiply/divide results, latency, back-to-back
// launch, divide-by-zero and overflow, MTHI/MTLO rules and mid-operation reset.
module tb_mdu_hilo;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W), .ITER(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] old_hi, old_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; afterwards scramble operands to prove they were latched.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.rs_in = a;
    bus.rt_in = b;
    bus.start = 1'b1;
    old_hi    = bus.hi_out;
    old_lo    = bus.lo_out;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.rs_in = ~a;
    bus.rt_in = ~b;
  endtask

  // Wait (bounded) for done; n0 is the cycle number after launch we are currently in.
  task automatic finish_op(input string tag, input int n0,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    bit busy_ok;
    bit hold_ok;
    n       = n0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.hi_out !== old_hi || bus.lo_out !== old_lo) hold_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd34);
    chk({tag, ".busy_during_op"}, 64'(busy_ok), 64'd1);
    chk({tag, ".hilo_held"}, 64'(hold_ok), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, ".hi"}, 64'(bus.hi_out), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(bus.lo_out), 64'(exp_lo));
  endtask

  initial begin
    bit done_seen;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs_in = '0;
    bus.rt_in = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.hi", 64'(bus.hi_out), 64'd0);
    chk("reset.lo", 64'(bus.lo_out), 64'd0);
    tick();

    // MULTU max * max
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1, 32'hFFFF_FFFE, 32'h0000_0001);

    // MULT -7 * 3, launched from DONE (no idle cycle), twice
    launch(2'b00, 32'hFFFF_FFF9, 32'd3);
    finish_op("mult_m7x3", 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    launch(2'b00, 32'hFFFF_FFF9, 32'd3);
    finish_op("mult_m7x3_b2b", 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // DIV -7 / 2, back-to-back again
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7d2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIVU 100 / 7 with mthi/mtlo asserted alongside start: writes must be dropped
    tick();
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    launch(2'b11, 32'd100, 32'd7);
    finish_op("divu_100d7_start_mt", 1, 32'd2, 32'd14);

    // Signed overflow
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 1, 32'h0000_0000, 32'h8000_0000);

    // Divide by zero, unsigned and signed
    launch(2'b11, 32'd5, 32'd0);
    finish_op("divu_5d0", 1, 32'd5, 32'hFFFF_FFFF);
    launch(2'b10, 32'hFFFF_FFFB, 32'd0);
    finish_op("div_m5d0", 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTHI while idle, then MTHI+MTLO together
    tick();
    bus.rs_in = 32'h1234_5678;
    bus.mthi  = 1'b1;
    tick();
    bus.mthi = 1'b0;
    chk("mthi.hi", 64'(bus.hi_out), 64'h1234_5678);
    chk("mthi.lo_kept", 64'(bus.lo_out), 64'hFFFF_FFFF);
    bus.rs_in = 32'hCAFE_F00D;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthilo.hi", 64'(bus.hi_out), 64'hCAFE_F00D);
    chk("mthilo.lo", 64'(bus.lo_out), 64'hCAFE_F00D);

    // MTLO during busy is ignored
    launch(2'b01, 32'd6, 32'd7);
    tick();
    bus.rs_in = 32'hDEAD_BEEF;
    bus.mtlo  = 1'b1;
    tick();
    tick();
    tick();
    chk("mtlo_busy.lo_held", 64'(bus.lo_out), 64'hCAFE_F00D);
    bus.mtlo = 1'b0;
    finish_op("multu_6x7", 5, 32'd0, 32'd42);

    // Reset in cycle 10 of a DIV
    tick();
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.done", 64'(bus.done), 64'd0);
    chk("rst_mid.hi", 64'(bus.hi_out), 64'd0);
    chk("rst_mid.lo", 64'(bus.lo_out), 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      tick();
    end
    chk("rst_mid.no_done", 64'(done_seen), 64'd0);

    // Fresh operation after the abort
    launch(2'b11, 32'd100, 32'd7);
    finish_op("after_rst_divu", 1, 32'd2, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
